// File: rtl/h264frombytes.sv
// h264frombytes -- byte-to-bitfield unpacker (read side of h264tobytes).
//
// Bytes arrive MSB-first over STROBE/BREADY and are buffered in a 40-bit
// MSB-aligned shift register. The downstream parser requests VL bits
// (0..25, larger values saturate to 25) and receives them right-justified
// on VE, handshaked with VALID/READY. A push and a pop may share a cycle.
//
// Ports:
//   CLK     clock, rising edge
//   RESET   synchronous active-high reset
//   BYTE    input byte, MSB is earliest in the stream
//   STROBE  BYTE valid this cycle
//   DONE    with STROBE: BYTE is the last byte of the stream
//   BREADY  unpacker accepts a byte this cycle
//   VL      requested field length
//   READY   downstream consumes the field this cycle
//   VALID   VE holds a complete field (or the stream tail once ended)
//   VE      next min(VL,count) bits, right-justified
//   EOS     stream ended and buffer empty
//
// Build option: define H264FROMBYTES_EPB_EN to strip emulation-prevention
// bytes (0x03 following two accepted 0x00 bytes).
module h264frombytes (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [7:0]  BYTE,
  input  logic        STROBE,
  input  logic        DONE,
  output logic        BREADY,
  input  logic [4:0]  VL,
  input  logic        READY,
  output logic        VALID,
  output logic [24:0] VE,
  output logic        EOS
);

  localparam int DATA_W = 8;
  localparam int BUF_W  = 40;
  localparam int FLD_W  = 25;

  function automatic logic [4:0] sat_len(input logic [4:0] vl);
    return (vl > 5'(FLD_W)) ? 5'(FLD_W) : vl;
  endfunction

  function automatic logic [1:0] sat_zrun(input logic [1:0] z);
    return (z == 2'd2) ? 2'd2 : z + 2'd1;
  endfunction

  logic [BUF_W-1:0] bits_p1;
  logic [5:0]       cnt_p1;
  logic             ended_p1;

  logic [4:0]       len;
  logic [5:0]       len6;
  logic [5:0]       take;
  logic [5:0]       rem;
  logic             accept;
  logic             insert;
  logic [BUF_W-1:0] bits_next;
  logic [5:0]       cnt_next;

`ifdef H264FROMBYTES_EPB_EN
  logic [1:0]       zrun_p1;
  logic [1:0]       zrun_next;
  logic             discard;
`endif

  // Field extraction: invariant keeps every bit below the valid region zero,
  // so a plain shift yields both the normal field and the zero-padded tail.
  always_comb begin
    len    = sat_len(VL);
    len6   = {1'b0, len};
    BREADY = !ended_p1 && (cnt_p1 <= 6'd32);
    EOS    = ended_p1 && (cnt_p1 == 6'd0);
    VALID  = (cnt_p1 >= len6) || (ended_p1 && (cnt_p1 != 6'd0));
    VE     = bits_p1[BUF_W-1 -: FLD_W] >> (5'(FLD_W) - len);
  end

  // Pop, then append the accepted byte right after the surviving bits.
  always_comb begin
    take   = 6'd0;
    if (VALID && READY)
      take = (len6 < cnt_p1) ? len6 : cnt_p1;
    rem    = cnt_p1 - take;
    accept = STROBE && BREADY;
`ifdef H264FROMBYTES_EPB_EN
    discard   = (BYTE == 8'h03) && (zrun_p1 == 2'd2);
    insert    = accept && !discard;
    zrun_next = zrun_p1;
    if (accept)
      zrun_next = (discard || BYTE != 8'h00) ? 2'd0 : sat_zrun(zrun_p1);
`else
    insert = accept;
`endif
    bits_next = bits_p1 << take;
    cnt_next  = rem;
    if (insert) begin
      bits_next = bits_next | ({BYTE, {(BUF_W-DATA_W){1'b0}}} >> rem);
      cnt_next  = rem + 6'd8;
    end
  end

  // State register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      bits_p1  <= '0;
      cnt_p1   <= 6'd0;
      ended_p1 <= 1'b0;
`ifdef H264FROMBYTES_EPB_EN
      zrun_p1  <= 2'd0;
`endif
    end else begin
      bits_p1  <= bits_next;
      cnt_p1   <= cnt_next;
      ended_p1 <= ended_p1 || (accept && DONE);
`ifdef H264FROMBYTES_EPB_EN
      zrun_p1  <= zrun_next;
`endif
    end
  end

endmodule

// File: tb/tb_h264frombytes.sv
// Directed bench for h264frombytes: reset values, field extraction, mixed
// push/pop streaming, full-buffer back-pressure, end-of-stream tail and
// emulation-prevention handling.
module tb_h264frombytes;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BYTE;
  logic        STROBE;
  logic        DONE;
  logic        BREADY;
  logic [4:0]  VL;
  logic        READY;
  logic        VALID;
  logic [24:0] VE;
  logic        EOS;

  int errors = 0;
  int checks = 0;

  h264frombytes dut (
    .CLK(CLK), .RESET(RESET), .BYTE(BYTE), .STROBE(STROBE), .DONE(DONE),
    .BREADY(BREADY), .VL(VL), .READY(READY), .VALID(VALID), .VE(VE), .EOS(EOS)
  );

  always #5 CLK = ~CLK;

`ifdef H264FROMBYTES_EPB_EN
  localparam logic [23:0] EPB_VE  = 24'h000001;
  localparam int          EPB_CNT = 0;
`else
  localparam logic [23:0] EPB_VE  = 24'h000003;
  localparam int          EPB_CNT = 8;
`endif

  task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input logic [7:0] b, input logic d);
    STROBE = 1'b1;
    BYTE   = b;
    DONE   = d;
    tick();
    STROBE = 1'b0;
    DONE   = 1'b0;
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
  endtask

  // Infer buffer occupancy in stream mode from VALID against VL.
  task automatic probe_count(input string tag, input int n);
    READY = 1'b0;
    if (n == 0) begin
      VL = 5'd1;
      #1 chk(tag, {39'd0, VALID}, 40'd0);
    end else begin
      VL = 5'(n);
      #1 chk(tag, {39'd0, VALID}, 40'd1);
      if (n < 25) begin
        VL = 5'(n + 1);
        #1 chk(tag, {39'd0, VALID}, 40'd0);
      end
    end
  endtask

  initial begin
    logic [7:0] bytes3 [6];
    logic [3:0] nib_q [$];
    bit         drained;

    RESET = 1'b1; BYTE = 8'h00; STROBE = 1'b0; DONE = 1'b0;
    VL = 5'd0; READY = 1'b0;
    tick();
    tick();

    // Reset values
    #1 chk("rst_bready", {39'd0, BREADY}, 40'd1);
    chk("rst_eos", {39'd0, EOS}, 40'd0);
    chk("rst_valid_vl0", {39'd0, VALID}, 40'd1);
    chk("rst_ve_vl0", {15'd0, VE}, 40'd0);
    VL = 5'd5;
    #1 chk("rst_valid_vl5", {39'd0, VALID}, 40'd0);
    chk("rst_ve_vl5", {15'd0, VE}, 40'd0);
    RESET = 1'b0;
    tick();

    // Four bytes into a 25-bit field
    READY = 1'b1; VL = 5'd25;
    push(8'h00, 1'b0);
    push(8'h6E, 1'b0);
    push(8'hEA, 1'b0);
    STROBE = 1'b1; BYTE = 8'h80;
    #1 chk("t1_not_yet_valid", {39'd0, VALID}, 40'd0);
    tick();
    STROBE = 1'b0;
    READY = 1'b0; VL = 5'd31;
    #1 chk("t1_valid_sat", {39'd0, VALID}, 40'd1);
    chk("t1_ve_sat", {15'd0, VE}, 40'd56789);
    VL = 5'd25; READY = 1'b1;
    #1 chk("t1_ve", {15'd0, VE}, 40'd56789);
    tick();
    probe_count("t1_count7", 7);

    // Mid-stream reset, then short fields
    do_reset();
    probe_count("t2_count0_after_reset", 0);
    push(8'hA5, 1'b0);
    READY = 1'b1; VL = 5'd3;
    #1 chk("t2_valid3", {39'd0, VALID}, 40'd1);
    chk("t2_ve3", {15'd0, VE}, 40'h5);
    tick();
    VL = 5'd5;
    #1 chk("t2_ve5", {15'd0, VE}, 40'h05);
    tick();
    READY = 1'b0; VL = 5'd1;
    #1 chk("t2_empty", {39'd0, VALID}, 40'd0);

    // Continuous push with 4-bit pops
    do_reset();
    bytes3 = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    READY = 1'b1; VL = 5'd4;
    for (int i = 0; i < 6; i++) begin
      STROBE = 1'b1; BYTE = bytes3[i];
      #1 chk("t3_bready", {39'd0, BREADY}, 40'd1);
      if (VALID) nib_q.push_back(VE[3:0]);
      tick();
    end
    STROBE = 1'b0;
    drained = 1'b0;
    for (int c = 0; c < 20 && !drained; c++) begin
      #1;
      if (!VALID) drained = 1'b1;
      else begin
        nib_q.push_back(VE[3:0]);
        tick();
      end
    end
    chk("t3_drained", {39'd0, drained}, 40'd1);
    chk("t3_nibble_count", 40'(nib_q.size()), 40'd12);
    for (int i = 0; i < 12; i++) begin
      logic [7:0] b;
      b = bytes3[i/2];
      if (i < nib_q.size())
        chk("t3_nibble", {36'd0, nib_q[i]}, {36'd0, (i % 2 == 0) ? b[7:4] : b[3:0]});
    end

    // Full buffer back-pressure; the byte offered while full is dropped
    do_reset();
    READY = 1'b0;
    push(8'hC3, 1'b0);
    push(8'h5A, 1'b0);
    push(8'h11, 1'b0);
    push(8'h22, 1'b0);
    #1 chk("t4_bready_at32", {39'd0, BREADY}, 40'd1);
    push(8'h33, 1'b0);
    #1 chk("t4_bready_full", {39'd0, BREADY}, 40'd0);
    STROBE = 1'b1; BYTE = 8'hEE; READY = 1'b1; VL = 5'd16;
    #1 chk("t4_valid16", {39'd0, VALID}, 40'd1);
    chk("t4_ve16", {15'd0, VE}, 40'hC35A);
    chk("t4_bready_same_cycle", {39'd0, BREADY}, 40'd0);
    tick();
    STROBE = 1'b0; READY = 1'b0;
    #1 chk("t4_bready_after_pop", {39'd0, BREADY}, 40'd1);
    probe_count("t4_count24", 24);
    VL = 5'd24;
    #1 chk("t4_tail", {15'd0, VE}, 40'h112233);

    // End of stream with a short tail
    do_reset();
    push(8'hF0, 1'b1);
    #1 chk("t5_bready_ended", {39'd0, BREADY}, 40'd0);
    chk("t5_eos_pending", {39'd0, EOS}, 40'd0);
    VL = 5'd12; READY = 1'b1;
    #1 chk("t5_valid", {39'd0, VALID}, 40'd1);
    chk("t5_ve", {15'd0, VE}, 40'hF00);
    tick();
    READY = 1'b0;
    #1 chk("t5_eos", {39'd0, EOS}, 40'd1);
    chk("t5_bready", {39'd0, BREADY}, 40'd0);
    chk("t5_valid_empty", {39'd0, VALID}, 40'd0);

    // Emulation-prevention sequence
    do_reset();
    push(8'h00, 1'b0);
    push(8'h00, 1'b0);
    push(8'h03, 1'b0);
    push(8'h01, 1'b0);
    VL = 5'd24; READY = 1'b1;
    #1 chk("t6_valid", {39'd0, VALID}, 40'd1);
    chk("t6_ve", {15'd0, VE}, {16'd0, EPB_VE});
    tick();
    probe_count("t6_count", EPB_CNT);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
